// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM states, default widths
// and the quotient reported for a divide by zero.
package arith_pkg;

  localparam int DW = 16;  // dividend / quotient width
  localparam int VW = 8;   // divisor / remainder width
  localparam int CW = 5;   // iteration counter width, 2**CW > DW

  localparam logic [DW-1:0] DIV0_QUOTIENT = {DW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage : arith_pkg

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift the partial remainder left,
// bring in the next dividend bit, and subtract the divisor if it fits.
// Purely combinational so it can be chained in an unrolled divider.
module restoring_div_step #(
  parameter int VW = 8
) (
  input  logic [VW:0]   i_rem,
  input  logic          i_bit,
  input  logic [VW-1:0] i_divisor,
  output logic [VW:0]   o_next_rem,
  output logic          o_q_bit
);

  logic [VW+1:0] w_shifted;
  logic          w_take;
  logic [VW:0]   w_sub;

  // The full shifted value (including the overflow bit) drives the compare,
  // so the trial subtraction never needs a separate borrow chain.
  assign w_shifted  = {i_rem, i_bit};
  assign w_take     = (w_shifted >= {2'b00, i_divisor});
  assign w_sub      = w_take ? {1'b0, i_divisor} : {(VW+1){1'b0}};
  assign o_next_rem = w_shifted[VW:0] - w_sub;
  assign o_q_bit    = w_take;

endmodule : restoring_div_step

// File: rtl/seq_div_16x8.sv
// Sequential radix-2 restoring divider: DW-bit dividend / VW-bit divisor,
// one quotient bit per clock, valid/ready handshake on both sides.
module seq_div_16x8 #(
  parameter int DW = arith_pkg::DW,
  parameter int VW = arith_pkg::VW,
  parameter int CW = arith_pkg::CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  import arith_pkg::*;

  div_state_t    r_state;
  div_state_t    w_state_next;
  logic [DW-1:0] r_shift;     // dividend shifts out the top, quotient fills the bottom
  logic [VW-1:0] r_divisor;
  logic [VW:0]   r_rem;       // one extra bit holds the shift overflow
  logic [CW-1:0] r_cnt;
  logic          r_dbz;
  logic          w_accept;
  logic          w_last_iter;
  logic [VW:0]   w_next_rem;
  logic          w_q_bit;

  assign w_accept    = in_valid && (r_state == ST_IDLE);
  assign w_last_iter = (r_cnt == CW'(DW-1));

  restoring_div_step #(.VW(VW)) u_step (
    .i_rem      (r_rem),
    .i_bit      (r_shift[DW-1]),
    .i_divisor  (r_divisor),
    .o_next_rem (w_next_rem),
    .o_q_bit    (w_q_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode. A divide by zero spends one RUN cycle with its
  // result already loaded so its latency is one clock after accept.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_dbz || w_last_iter) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, iterate in RUN, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= {DW{1'b0}};
      r_divisor <= {VW{1'b0}};
      r_rem     <= {(VW+1){1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_divisor <= divisor;
            r_rem     <= {(VW+1){1'b0}};
            r_cnt     <= {CW{1'b0}};
            if (divisor == {VW{1'b0}}) begin
              r_shift <= {DW{1'b1}};
              r_dbz   <= 1'b1;
            end else begin
              r_shift <= dividend;
              r_dbz   <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (!r_dbz) begin
            r_rem   <= w_next_rem;
            r_shift <= {r_shift[DW-2:0], w_q_bit};
            r_cnt   <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          r_dbz <= r_dbz;
        end
        default: begin
          r_dbz <= r_dbz;
        end
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign quotient    = r_shift;
  assign remainder   = r_rem[VW-1:0];
  assign div_by_zero = r_dbz;

endmodule : seq_div_16x8

// File: tb/tb_seq_div_16x8.sv
// Directed self-checking bench for seq_div_16x8.
module tb_seq_div_16x8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int pass_cnt;
  int total_cnt;

  seq_div_16x8 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands and let the next rising edge accept them.
  task automatic issue(input logic [15:0] a, input logic [7:0] b);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid; 40 means timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (quotient !== 16'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0)
      $display("FAIL reset_outputs got q=%0d r=%0d dbz=%b want 0 0 0", quotient, remainder, div_by_zero);
    else pass_cnt++;
    #4 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    issue(16'd1000, 8'd7);
    wait_done(lat);
    total_cnt++;
    if (lat !== 16) $display("FAIL basic_latency got %0d want 16", lat);
    else pass_cnt++;
    total_cnt++;
    if (quotient !== 16'd142 || remainder !== 8'd6 || div_by_zero !== 1'b0)
      $display("FAIL basic_result got q=%0d r=%0d dbz=%b want 142 6 0", quotient, remainder, div_by_zero);
    else pass_cnt++;
    retire();
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL basic_retire got ov=%b ir=%b want 0 1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_edges();
    logic [15:0] vec_a [4];
    logic [7:0]  vec_b [4];
    logic [15:0] vec_q [4];
    logic [7:0]  vec_r [4];
    logic [7:0]  m;
    logic [15:0] prod;
    int lat;
    m    = 8'd255;
    prod = 16'(m) * 16'(m);   // what the 8x8 multiplier produces for 255x255
    vec_a[0] = prod;      vec_b[0] = 8'd255; vec_q[0] = 16'd255;   vec_r[0] = 8'd0;
    vec_a[1] = 16'd65535; vec_b[1] = 8'd1;   vec_q[1] = 16'd65535; vec_r[1] = 8'd0;
    vec_a[2] = 16'd5;     vec_b[2] = 8'd200; vec_q[2] = 16'd0;     vec_r[2] = 8'd5;
    vec_a[3] = 16'd65535; vec_b[3] = 8'd255; vec_q[3] = 16'd257;   vec_r[3] = 8'd0;
    for (int i = 0; i < 4; i++) begin
      issue(vec_a[i], vec_b[i]);
      wait_done(lat);
      total_cnt++;
      if (lat !== 16 || quotient !== vec_q[i] || remainder !== vec_r[i] || div_by_zero !== 1'b0)
        $display("FAIL edge_%0d got lat=%0d q=%0d r=%0d dbz=%b want 16 %0d %0d 0",
                 i, lat, quotient, remainder, div_by_zero, vec_q[i], vec_r[i]);
      else pass_cnt++;
      retire();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    issue(16'd100, 8'd0);
    wait_done(lat);
    total_cnt++;
    if (lat !== 1) $display("FAIL dbz_latency got %0d want 1", lat);
    else pass_cnt++;
    total_cnt++;
    if (quotient !== 16'hFFFF || remainder !== 8'd0 || div_by_zero !== 1'b1)
      $display("FAIL dbz_result got q=%h r=%0d dbz=%b want ffff 0 1", quotient, remainder, div_by_zero);
    else pass_cnt++;
    retire();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(16'd1000, 8'd7);
    wait_done(lat);
    // new operands presented while DONE must be ignored
    dividend = 16'd12345;
    divisor  = 8'd3;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      total_cnt++;
      if (quotient !== 16'd142 || remainder !== 8'd6 || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL hold_cycle_%0d got q=%0d r=%0d ov=%b ir=%b want 142 6 1 0",
                 c, quotient, remainder, out_valid, in_ready);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL retire_with_valid got ov=%b ir=%b want 0 1", out_valid, in_ready);
    else pass_cnt++;
    issue(16'd5, 8'd200);
    wait_done(lat);
    total_cnt++;
    if (quotient !== 16'd0 || remainder !== 8'd5)
      $display("FAIL back_to_back got q=%0d r=%0d want 0 5", quotient, remainder);
    else pass_cnt++;
    retire();
  endtask

  task automatic test_reset_midrun();
    int lat;
    int spurious;
    issue(16'd300, 8'd9);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if (quotient !== 16'd0 || remainder !== 8'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midrun_reset got q=%0d r=%0d ov=%b ir=%b want 0 0 0 1",
               quotient, remainder, out_valid, in_ready);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    spurious = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) spurious++;
    end
    total_cnt++;
    if (spurious !== 0) $display("FAIL midrun_spurious got %0d want 0", spurious);
    else pass_cnt++;
    issue(16'd300, 8'd9);
    wait_done(lat);
    total_cnt++;
    if (lat !== 16 || quotient !== 16'd33 || remainder !== 8'd3)
      $display("FAIL midrun_reissue got lat=%0d q=%0d r=%0d want 16 33 3", lat, quotient, remainder);
    else pass_cnt++;
    retire();
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0]  b;
    logic [23:0] recon;
    int lat;
    for (int n = 0; n < 2000; n++) begin
      a = 16'($urandom_range(65535, 0));
      b = 8'($urandom_range(255, 1));
      issue(a, b);
      wait_done(lat);
      recon = 24'(quotient) * 24'(b) + 24'(remainder);
      total_cnt++;
      if (lat !== 16 || recon !== 24'(a) || remainder >= b || div_by_zero !== 1'b0)
        $display("FAIL random_%0d %0d/%0d got q=%0d r=%0d lat=%0d", n, a, b, quotient, remainder, lat);
      else pass_cnt++;
      retire();
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 16'd0;
    divisor   = 8'd0;
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_seq_div_16x8
